rtlola_offset_pipeline: RTL

//  Parametrised monitor core for an RTLola chain of offset streams: one signed input stream x and

---
 rtl/rtlola_offset_pipeline_pkg.sv | 10 +
 rtl/rtlola_event_queue.sv | 40 ++++
 rtl/rtlola_offset_pipeline.sv | 69 ++++++
 3 files changed

// File: rtl/rtlola_offset_pipeline_pkg.sv
// rtlola_offset_pipeline_pkg: shared defaults and helpers for the offset-stream monitor core
package rtlola_offset_pipeline_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_STAGES = 4;
  localparam int DEF_QUEUE_DEPTH = 4;
  localparam int OFFSET_DEFAULT = 0;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rtlola_event_queue.sv
// rtlola_event_queue: circular FIFO holding input events while evaluation is frozen
module rtlola_event_queue
  import rtlola_offset_pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign dout = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/rtlola_offset_pipeline.sv
// rtlola_offset_pipeline: chain of offset streams s_k(e)=s_(k-1)(e)+s_(k-1)(e-1), one layer per clock
module rtlola_offset_pipeline
  import rtlola_offset_pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [WIDTH-1:0]                 input_x,
  input  logic                             new_input,
  output logic [STAGES*WIDTH-1:0]          out_data,
  output logic [STAGES-1:0]                out_aktv,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic                             overflow
);
  logic [WIDTH-1:0] q_dout, issue_x;
  logic q_full, q_empty, q_push, q_pop, issue_v;
  // Queue has priority over a fresh event so arrival order is preserved.
  always_comb begin
    q_pop = en && !q_empty;
    q_push = new_input && (en ? !q_empty : !q_full);
    issue_v = en && (!q_empty || new_input);
    issue_x = q_empty ? input_x : q_dout;
  end
  rtlola_event_queue #(.WIDTH(WIDTH), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(q_push),
    .pop(q_pop),
    .din(input_x),
    .dout(q_dout),
    .full(q_full),
    .empty(q_empty),
    .count(queue_count)
  );
  always_ff @(posedge clk) begin
    if (!rst) overflow <= 1'b0;
    else if (!en && new_input && q_full) overflow <= 1'b1;
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_layer
    logic [WIDTH-1:0] op_x, data_q, prev_q;
    logic op_v, aktv_q;
    if (k == 0) begin : g_src
      assign op_v = issue_v;
      assign op_x = issue_x;
    end else begin : g_src
      assign op_v = out_aktv[k-1];
      assign op_x = out_data[(k-1)*WIDTH +: WIDTH];
    end
    always_ff @(posedge clk) begin
      if (!rst) begin
        data_q <= '0;
        prev_q <= WIDTH'(OFFSET_DEFAULT);
        aktv_q <= 1'b0;
      end else if (en) begin
        aktv_q <= op_v;
        if (op_v) begin
          data_q <= op_x + prev_q;
          prev_q <= op_x;
        end
      end
    end
    assign out_data[k*WIDTH +: WIDTH] = data_q;
    assign out_aktv[k] = aktv_q;
  end
endmodule
